// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: two-to-one I-cache/D-cache arbiter for a single external memory port
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   i_read_request/i_addr      I-cache read request (level) and address
//   i_response/i_read_data     one-cycle I-cache done pulse with read data
//   d_read_request/d_write_request/d_addr/d_write_data   D-cache request (level), write wins
//   d_response/d_read_data     one-cycle D-cache done pulse with read data
//   memory_read_request/memory_write_request/memory_addr/memory_write_data   registered memory strobes
//   memory_response/memory_read_data   memory done pulse with read data
// Macro CACHE_ARB_ROUND_ROBIN_EN: round-robin arbitration; otherwise D always wins over I.
`timescale 1ns/1ps
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read_request,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_response,
    output logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  d_read_request,
    input  logic                  d_write_request,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic                  d_response,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  memory_read_request,
    output logic                  memory_write_request,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [DATA_WIDTH-1:0] memory_write_data,
    input  logic                  memory_response,
    input  logic [DATA_WIDTH-1:0] memory_read_data
);
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
    state_t state;
    logic   owner_d;
    logic   d_req;
    logic   grant_d;
    logic   grant_wr;
    assign d_req = d_read_request | d_write_request;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic prefer_d;
    assign grant_d = d_req && (!i_read_request || prefer_d);
`else
    assign grant_d = d_req;
`endif
    assign grant_wr = grant_d && d_write_request;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            owner_d              <= 1'b0;
            i_response           <= 1'b0;
            d_response           <= 1'b0;
            i_read_data          <= '0;
            d_read_data          <= '0;
            memory_read_request  <= 1'b0;
            memory_write_request <= 1'b0;
            memory_addr          <= '0;
            memory_write_data    <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            prefer_d             <= 1'b1;
`endif
        end else begin
            i_response <= 1'b0;
            d_response <= 1'b0;
            case (state)
                IDLE: if (i_read_request || d_req) begin
                    state                <= MEM;
                    owner_d              <= grant_d;
                    memory_addr          <= grant_d ? d_addr : i_addr;
                    memory_write_data    <= grant_wr ? d_write_data : '0;
                    memory_write_request <= grant_wr;
                    memory_read_request  <= !grant_wr;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    // pointer always moves to the requester that was not just granted
                    prefer_d             <= !grant_d;
`endif
                end
                MEM: if (memory_response) begin
                    state                <= RESP;
                    memory_read_request  <= 1'b0;
                    memory_write_request <= 1'b0;
                    // read data is captured for writes too; the requester ignores it
                    if (owner_d) begin
                        d_read_data <= memory_read_data;
                        d_response  <= 1'b1;
                    end else begin
                        i_read_data <= memory_read_data;
                        i_response  <= 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter with a behavioural memory and reference model
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    logic        clk = 0;
    logic        reset;
    logic        i_read_request, d_read_request, d_write_request;
    logic [31:0] i_addr, d_addr, d_write_data;
    logic        i_response, d_response;
    logic [31:0] i_read_data, d_read_data;
    logic        memory_read_request, memory_write_request, memory_response;
    logic [31:0] memory_addr, memory_write_data, memory_read_data;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .i_read_request(i_read_request), .i_addr(i_addr),
        .i_response(i_response), .i_read_data(i_read_data),
        .d_read_request(d_read_request), .d_write_request(d_write_request),
        .d_addr(d_addr), .d_write_data(d_write_data),
        .d_response(d_response), .d_read_data(d_read_data),
        .memory_read_request(memory_read_request), .memory_write_request(memory_write_request),
        .memory_addr(memory_addr), .memory_write_data(memory_write_data),
        .memory_response(memory_response), .memory_read_data(memory_read_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] i_exp[$];
    logic [31:0] d_exp[$];
    bit          grant_log[$];
    int  fixed_delay = -1;
    int  resp_delay = 0;
    bit  mem_hold = 0;
    bit  stray = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // memory device: responds after a chosen number of extra MEM cycles, returns old contents
    initial begin
        int mem_wait = -1;
        memory_response = 0;
        memory_read_data = 0;
        forever begin
            @(posedge clk); #1;
            memory_response = 0;
            if (reset) mem_wait = -1;
            else if (memory_read_request || memory_write_request) begin
                if (mem_wait < 0) begin
                    mem_wait = fixed_delay >= 0 ? fixed_delay : $urandom_range(0, 3);
                    resp_delay = mem_wait;
                end
                if (!mem_hold) begin
                    if (mem_wait == 0) begin
                        memory_response = 1;
                        memory_read_data = mem.exists(memory_addr) ? mem[memory_addr] : dflt(memory_addr);
                        if (memory_write_request) mem[memory_addr] = memory_write_data;
                        mem_wait = -1;
                    end else mem_wait--;
                end
            end else begin
                mem_wait = -1;
                if (stray) begin
                    memory_response = 1;
                    memory_read_data = 32'hBAD0_BAD0;
                    stray = 0;
                end
            end
        end
    end

    // requests exactly as the arbiter sampled them on each rising edge
    logic        snap_i, snap_d, snap_dw;
    logic [31:0] snap_ia, snap_da, snap_dwd;
    initial forever begin
        @(posedge clk);
        snap_i = i_read_request;
        snap_d = d_read_request | d_write_request;
        snap_dw = d_write_request;
        snap_ia = i_addr;
        snap_da = d_addr;
        snap_dwd = d_write_data;
    end

    // monitor: grant decision, memory-side op, and response scoreboard
    initial begin
        bit          in_mem = 0, last_d = 0, own_d = 0, exp_wr = 0, i_prev = 0, d_prev = 0, pref_d;
        int          mem_cnt = 0;
        logic [31:0] exp_addr = 0, exp_wd = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_mem = 0; last_d = 0; i_prev = 0; d_prev = 0;
            end else begin
                if (memory_read_request && memory_write_request) chk("strobe_exclusive", 1, 0);
                if ((memory_read_request || memory_write_request) && !in_mem) begin
                    in_mem = 1;
                    mem_cnt = 1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    pref_d = !last_d;
`else
                    pref_d = 1;
`endif
                    if (!snap_i && !snap_d) chk("spurious_grant", 1, 0);
                    own_d = (snap_i && snap_d) ? pref_d : snap_d;
                    last_d = own_d;
                    grant_log.push_back(own_d);
                    exp_wr = own_d && snap_dw;
                    exp_addr = own_d ? snap_da : snap_ia;
                    exp_wd = exp_wr ? snap_dwd : 32'h0;
                    chk("grant_addr", memory_addr, exp_addr);
                    chk("grant_wdata", memory_write_data, exp_wd);
                    chk("grant_op", {memory_read_request, memory_write_request}, {!exp_wr, exp_wr});
                end else if (memory_read_request || memory_write_request) begin
                    mem_cnt++;
                    chk("mem_stable", {memory_addr, memory_write_data}, {exp_addr, exp_wd});
                end else if (in_mem) begin
                    in_mem = 0;
                    chk("mem_cycles", mem_cnt, resp_delay + 1);
                    chk("resp_owner", {d_response, i_response}, {own_d, !own_d});
                end
                if (i_response) begin
                    chk("i_pulse_len", i_prev, 0);
                    if (i_exp.size() == 0) chk("i_unexpected", 1, 0);
                    else chk("i_data", i_read_data, i_exp.pop_front());
                end
                if (d_response) begin
                    chk("d_pulse_len", d_prev, 0);
                    if (d_exp.size() == 0) chk("d_unexpected", 1, 0);
                    else chk("d_data", d_read_data, d_exp.pop_front());
                end
                i_prev = i_response;
                d_prev = d_response;
            end
        end
    end

    task automatic i_txn(input logic [31:0] a, input bit drop);
        bit got = 0;
        @(posedge clk); #1;
        i_addr = a;
        i_read_request = 1;
        i_exp.push_back(ref_rd(a));
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (i_response) got = 1;
            else if (drop && memory_read_request) i_read_request = 0;
        end
        chk("i_timeout", got, 1);
        i_read_request = 0;
    endtask

    task automatic d_txn(input logic [31:0] a, input logic [31:0] wd, input bit wr, input bit both);
        bit got = 0;
        @(posedge clk); #1;
        d_addr = a;
        d_write_data = wd;
        d_write_request = wr | both;
        d_read_request = !wr | both;
        d_exp.push_back(ref_rd(a));
        if (wr | both) ref_mem[a] = wd;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (d_response) got = 1;
        end
        chk("d_timeout", got, 1);
        d_read_request = 0;
        d_write_request = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_i_response"}, i_response, 0);
        chk({tag, "_d_response"}, d_response, 0);
        chk({tag, "_strobes"}, {memory_read_request, memory_write_request}, 0);
        chk({tag, "_memory_addr"}, memory_addr, 0);
        chk({tag, "_memory_write_data"}, memory_write_data, 0);
        chk({tag, "_i_read_data"}, i_read_data, 0);
        chk({tag, "_d_read_data"}, d_read_data, 0);
    endtask

    initial begin
        logic [3:0] ord;
        logic [3:0] exp_ord;
        bit         seen;
        reset = 1;
        i_read_request = 0; d_read_request = 0; d_write_request = 0;
        i_addr = 0; d_addr = 0; d_write_data = 0;
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk) reset = 0;

        // single I read, memory answers in the second MEM cycle
        mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        fixed_delay = 1;
        i_txn(32'h100, 0);
        chk("single_i_data", i_read_data, 32'hDEAD_BEEF);

        // D write, then both D strobes high (write wins)
        fixed_delay = 0;
        d_txn(32'h200, 32'h1234_5678, 1, 0);
        d_txn(32'h204, 32'hCAFE_F00D, 0, 1);
        fixed_delay = -1;

        // simultaneous I and D, each issuing two back-to-back reads
        grant_log.delete();
        fork
            begin i_txn(32'h1000_0010, 0); i_txn(32'h1000_0014, 0); end
            begin d_txn(32'h2000_0010, 32'h0, 0, 0); d_txn(32'h2000_0014, 32'h0, 0, 0); end
        join
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        exp_ord = 4'b1010;
`else
        exp_ord = 4'b1100;
`endif
        ord = 0;
        for (int k = 0; k < 4 && k < grant_log.size(); k++) ord = {ord[2:0], grant_log[k]};
        chk("order_count", grant_log.size(), 4);
        chk("order", ord, exp_ord);

        // request dropped while in MEM still completes; stray memory_response is ignored
        fixed_delay = 3;
        i_txn(32'h1000_0020, 1);
        fixed_delay = -1;
        repeat (2) @(negedge clk);
        stray = 1;
        repeat (4) begin
            @(negedge clk);
            chk("stray_no_pulse", {i_response, d_response}, 0);
        end

        // reset in the middle of a memory write
        mem_hold = 1;
        @(posedge clk); #1;
        d_addr = 32'h2000_0030; d_write_data = 32'h5555_AAAA; d_write_request = 1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = memory_write_request;
        end
        chk("reset_mid_wr_seen", seen, 1);
        #2 reset = 1;
        #1 chk_outputs_zero("reset_mid");
        @(negedge clk);
        d_write_request = 0;
        mem_hold = 0;
        @(negedge clk) reset = 0;
        repeat (6) begin
            @(negedge clk);
            chk("after_reset_no_pulse", {i_response, d_response}, 0);
        end

        // after reset the D side is preferred again
        grant_log.delete();
        fork
            i_txn(32'h1000_0040, 0);
            d_txn(32'h2000_0040, 32'h0, 0, 0);
        join
        chk("post_reset_first_d", grant_log.size() > 0 ? grant_log[0] : 1'b0, 1);

        // random traffic from both caches
        fork
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                i_txn(32'h1000_0000 | ($urandom_range(0, 255) << 2), 0);
            end
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                d_txn(32'h2000_0000 | ($urandom_range(0, 15) << 2), $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            end
        join

        repeat (5) @(negedge clk);
        chk("i_queue_empty", i_exp.size(), 0);
        chk("d_queue_empty", d_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
